// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory bus types: 32-bit word and the RAM handshake status.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;
endpackage

// File: rtl/ram_responder_pkg.sv
// Local helpers for the RAM responder: latency counter type and address legality.
package ram_responder_pkg;
  import cpu_types_pkg::*;

  localparam int unsigned LAT_MAX = 15;
  typedef logic [$clog2(LAT_MAX+1)-1:0] lat_cnt_t;

  function automatic logic addr_legal(input word_t addr, input int unsigned depth);
    return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth);
  endfunction
endpackage

// File: rtl/ram_responder_if.sv
// Memory controller <-> RAM request/response bus.
interface ram_responder_if;
  import cpu_types_pkg::*;

  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport master (output ramREN, ramWEN, ramaddr, ramstore, input ramload, ramstate);
  modport slave  (input ramREN, ramWEN, ramaddr, ramstore, output ramload, ramstate);
endinterface

// File: rtl/ram_responder_word_array.sv
// Single-port DEPTH x 32 word store; synchronous write and registered read, no reset.
module ram_word_array
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [AW-1:0] addr,
  input  word_t         wr_dat,
  output word_t         rd_dat
);
  word_t mem_q [DEPTH];
  word_t rd_dat_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[addr] <= wr_dat;
    if (rd_en) rd_dat_q    <= mem_q[addr];
  end

  assign rd_dat = rd_dat_q;
endmodule

// File: rtl/ram_responder.sv
// RAM endpoint: answers REN/WEN requests after LAT BUSY cycles with a one-cycle ACCESS,
// flags misaligned or out-of-range requests with ERROR.
module ram_responder
  import cpu_types_pkg::*;
  import ram_responder_pkg::*;
#(
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input logic             CLK,
  input logic             nRST,
  ram_responder_if.slave  ram
);
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DONE, R_ERR} rstate_e;

  localparam lat_cnt_t LAT_M1 = (LAT > 0) ? lat_cnt_t'(LAT - 1) : '0;

  rstate_e  state_q, state_d;
  lat_cnt_t cnt_q, cnt_d;
  logic     req_wr_q, req_wr_d;
  word_t    req_addr_q, req_addr_d;
  logic     load_vld_q, load_vld_d;

  logic  req_vld, req_legal, req_changed, start, access, wr_en, rd_en;
  word_t rd_dat;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    start       = 1'b0;
    req_vld     = ram.ramREN | ram.ramWEN;
    req_legal   = addr_legal(ram.ramaddr, DEPTH);
    req_changed = (ram.ramWEN != req_wr_q) || (ram.ramaddr != req_addr_q);
    req_wr_d    = ram.ramWEN;
    req_addr_d  = ram.ramaddr;

    unique case (state_q)
      R_IDLE: start = 1'b1;
      R_WAIT: begin
        if (!req_vld)           state_d = R_IDLE;
        else if (req_changed)   start   = 1'b1;
        else if (cnt_q == '0)   state_d = R_DONE;
        else                    cnt_d   = cnt_q - 1'b1;
      end
      R_DONE: state_d = R_IDLE;
      R_ERR: begin
        if (!req_vld)           state_d = R_IDLE;
        else if (req_changed)   start   = 1'b1;
      end
    endcase

    // A fresh or modified request is judged exactly as if arriving from idle.
    if (start) begin
      if (!req_vld)        state_d = R_IDLE;
      else if (!req_legal) state_d = R_ERR;
      else if (LAT > 0) begin
        state_d = R_WAIT;
        cnt_d   = LAT_M1;
      end else             state_d = R_DONE;
    end

    // R_DONE is never re-entered from itself, so this marks the entry edge only.
    access     = (state_d == R_DONE) && nRST;
    wr_en      = access &&  ram.ramWEN;
    rd_en      = access && !ram.ramWEN;
    load_vld_d = load_vld_q | rd_en;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q    <= R_IDLE;
      cnt_q      <= '0;
      req_wr_q   <= 1'b0;
      req_addr_q <= '0;
      load_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_wr_q   <= req_wr_d;
      req_addr_q <= req_addr_d;
      load_vld_q <= load_vld_d;
    end
  end

  ram_word_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk    (CLK),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .addr   (ram.ramaddr[AW+1:2]),
    .wr_dat (ram.ramstore),
    .rd_dat (rd_dat)
  );

  // The array has no reset, so the output is forced to zero until the first read.
  assign ram.ramload = load_vld_q ? rd_dat : '0;

  always_comb begin
    ram.ramstate = FREE;
    unique case (state_q)
      R_IDLE: ram.ramstate = FREE;
      R_WAIT: ram.ramstate = BUSY;
      R_DONE: ram.ramstate = ACCESS;
      R_ERR:  ram.ramstate = ERROR;
    endcase
  end
endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder at LAT=2, LAT=0 and LAT=3 against a transaction-level model.
module tb_ram_responder;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  ram_responder_if ri2 ();
  ram_responder_if ri0 ();
  ram_responder_if ri3 ();

  ram_responder #(.LAT(2)) dut2 (.CLK(CLK), .nRST(nRST), .ram(ri2));
  ram_responder #(.LAT(0)) dut0 (.CLK(CLK), .nRST(nRST), .ram(ri0));
  ram_responder #(.LAT(3)) dut3 (.CLK(CLK), .nRST(nRST), .ram(ri3));

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cs(input string nm, input ramstate_t got, input ramstate_t exp);
    check(nm, 32'(got), 32'(exp));
  endtask

  // Model: each instance tracks how many edges the current unchanged legal request has been held.
  localparam int NI = 3;
  int        lat_c [NI] = '{2, 0, 3};
  ramstate_t m_state [NI];
  int        m_age [NI];
  logic      m_prev_vld [NI];
  logic      m_prev_wr [NI];
  word_t     m_prev_addr [NI];
  word_t     m_load [NI];
  bit        m_load_known [NI];
  word_t     m_mem [int];

  task automatic model_step(input int i, input logic rst_n, input logic ren, input logic wen,
                            input word_t addr, input word_t store);
    logic vld, legal, same;
    int key;
    if (!rst_n) begin
      m_state[i] = FREE; m_load[i] = '0; m_load_known[i] = 1'b1; m_prev_vld[i] = 1'b0;
      return;
    end
    vld   = ren | wen;
    legal = (addr[1:0] == 2'b00) && (addr[31:2] < 30'd1024);
    same  = m_prev_vld[i] && (wen == m_prev_wr[i]) && (addr == m_prev_addr[i]);
    key   = i * 8192 + int'(addr[31:2] & 30'h3ff);
    if (m_state[i] == ACCESS || !vld) m_state[i] = FREE;
    else if (same && m_state[i] == ERROR) m_state[i] = ERROR;
    else if (same && m_state[i] == BUSY) begin
      m_age[i]++;
      m_state[i] = (m_age[i] >= lat_c[i]) ? ACCESS : BUSY;
    end else if (!legal) m_state[i] = ERROR;
    else begin
      m_age[i] = 0;
      m_state[i] = (lat_c[i] == 0) ? ACCESS : BUSY;
    end
    if (m_state[i] == ACCESS) begin
      if (wen) m_mem[key] = store;
      else if (m_mem.exists(key)) begin m_load[i] = m_mem[key]; m_load_known[i] = 1'b1; end
      else m_load_known[i] = 1'b0;
    end
    m_prev_vld[i] = vld; m_prev_wr[i] = wen; m_prev_addr[i] = addr;
  endtask

  always @(posedge CLK) begin
    model_step(0, nRST, ri2.ramREN, ri2.ramWEN, ri2.ramaddr, ri2.ramstore);
    model_step(1, nRST, ri0.ramREN, ri0.ramWEN, ri0.ramaddr, ri0.ramstore);
    model_step(2, nRST, ri3.ramREN, ri3.ramWEN, ri3.ramaddr, ri3.ramstore);
  end

  task automatic cmp(input int i, input ramstate_t st, input word_t ld);
    cs($sformatf("model_state%0d", i), st, m_state[i]);
    if (m_load_known[i]) check($sformatf("model_load%0d", i), ld, m_load[i]);
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      cmp(0, ri2.ramstate, ri2.ramload);
      cmp(1, ri0.ramstate, ri0.ramload);
      cmp(2, ri3.ramstate, ri3.ramload);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    ri2.ramREN = 0; ri2.ramWEN = 0; ri2.ramaddr = '0; ri2.ramstore = '0;
    ri0.ramREN = 0; ri0.ramWEN = 0; ri0.ramaddr = '0; ri0.ramstore = '0;
    ri3.ramREN = 0; ri3.ramWEN = 0; ri3.ramaddr = '0; ri3.ramstore = '0;

    // Reset then idle
    nRST = 1'b0;
    tick(); chk_en = 1'b1;
    tick(); nRST = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      cs("idle_state", ri2.ramstate, FREE);
      check("idle_load", ri2.ramload, 32'h0);
    end
    cs("idle_state_lat0", ri0.ramstate, FREE);
    cs("idle_state_lat3", ri3.ramstate, FREE);

    // LAT=2 write 0x40 then read it back
    ri2.ramWEN = 1; ri2.ramaddr = 32'h40; ri2.ramstore = 32'hDEADBEEF;
    tick(); cs("w40_b1", ri2.ramstate, BUSY);
    tick(); cs("w40_b2", ri2.ramstate, BUSY);
    tick(); cs("w40_acc", ri2.ramstate, ACCESS);
    check("w40_load_untouched", ri2.ramload, 32'h0);
    ri2.ramWEN = 0;
    tick(); cs("w40_free", ri2.ramstate, FREE);
    ri2.ramREN = 1;
    tick(); cs("r40_b1", ri2.ramstate, BUSY);
    tick(); cs("r40_b2", ri2.ramstate, BUSY);
    tick(); cs("r40_acc", ri2.ramstate, ACCESS);
    check("r40_load", ri2.ramload, 32'hDEADBEEF);
    ri2.ramREN = 0;
    tick(); check("r40_hold", ri2.ramload, 32'hDEADBEEF);

    // ramstore only matters at the ACCESS-entry edge
    ri2.ramWEN = 1; ri2.ramaddr = 32'h44; ri2.ramstore = 32'h1;
    tick(); ri2.ramstore = 32'h2;
    tick(); ri2.ramstore = 32'h55AA55AA;
    tick(); cs("w44_acc", ri2.ramstate, ACCESS);
    ri2.ramWEN = 0;
    tick();
    // REN and WEN together act as a write
    ri2.ramREN = 1; ri2.ramWEN = 1; ri2.ramaddr = 32'h48; ri2.ramstore = 32'hCAFEF00D;
    tick(); cs("rw48_b1", ri2.ramstate, BUSY);
    tick(); tick(); cs("rw48_acc", ri2.ramstate, ACCESS);
    check("rw48_load_untouched", ri2.ramload, 32'hDEADBEEF);
    ri2.ramWEN = 0; ri2.ramREN = 0;
    tick();
    ri2.ramREN = 1; ri2.ramaddr = 32'h44;
    tick(); tick(); tick(); check("r44_load", ri2.ramload, 32'h55AA55AA);
    ri2.ramREN = 0; tick();
    ri2.ramREN = 1; ri2.ramaddr = 32'h48;
    tick(); tick(); tick(); check("r48_load", ri2.ramload, 32'hCAFEF00D);
    ri2.ramREN = 0; tick();

    // LAT=0: write word 0 then hold a read for alternating ACCESS/FREE
    ri0.ramWEN = 1; ri0.ramaddr = 32'h0; ri0.ramstore = 32'hA5A50001;
    tick(); cs("l0_w_acc", ri0.ramstate, ACCESS);
    ri0.ramWEN = 0;
    tick(); cs("l0_w_free", ri0.ramstate, FREE);
    ri0.ramREN = 1;
    for (int k = 0; k < 2; k++) begin
      tick(); cs("l0_r_acc", ri0.ramstate, ACCESS);
      check("l0_r_load", ri0.ramload, 32'hA5A50001);
      tick(); cs("l0_r_free", ri0.ramstate, FREE);
    end
    ri0.ramREN = 0; tick();

    // LAT=3: seed words 2 and 3, then change address mid-BUSY
    ri3.ramWEN = 1; ri3.ramaddr = 32'h8; ri3.ramstore = 32'h00000088;
    repeat (4) tick();
    cs("l3_w8_acc", ri3.ramstate, ACCESS);
    ri3.ramWEN = 0; tick();
    ri3.ramWEN = 1; ri3.ramaddr = 32'hC; ri3.ramstore = 32'h00000C0C;
    repeat (4) tick();
    ri3.ramWEN = 0; tick();
    ri3.ramREN = 1; ri3.ramaddr = 32'h8;
    tick(); cs("l3_chg_b0", ri3.ramstate, BUSY);
    ri3.ramaddr = 32'hC;
    for (int k = 0; k < 3; k++) begin
      tick(); cs("l3_chg_busy", ri3.ramstate, BUSY);
    end
    tick(); cs("l3_chg_acc", ri3.ramstate, ACCESS);
    check("l3_chg_load", ri3.ramload, 32'h00000C0C);
    ri3.ramREN = 0; tick();
    // write aborted by dropping WEN leaves the word unchanged
    ri3.ramWEN = 1; ri3.ramaddr = 32'h8; ri3.ramstore = 32'h00000BAD;
    tick(); tick(); cs("l3_abort_busy", ri3.ramstate, BUSY);
    ri3.ramWEN = 0;
    tick(); cs("l3_abort_free", ri3.ramstate, FREE);
    ri3.ramREN = 1;
    repeat (4) tick();
    cs("l3_r8_acc", ri3.ramstate, ACCESS);
    check("l3_r8_load", ri3.ramload, 32'h00000088);
    ri3.ramREN = 0; tick();

    // Illegal requests on LAT=2
    ri2.ramREN = 1; ri2.ramaddr = 32'h42;
    tick(); cs("mis_err", ri2.ramstate, ERROR);
    for (int k = 0; k < 5; k++) begin
      tick(); cs("mis_err_hold", ri2.ramstate, ERROR);
    end
    ri2.ramREN = 0;
    tick(); cs("mis_free", ri2.ramstate, FREE);
    ri2.ramREN = 1; ri2.ramaddr = 32'h1000;
    tick(); cs("oor_err", ri2.ramstate, ERROR);
    ri2.ramaddr = 32'h40;
    tick(); cs("err_to_busy", ri2.ramstate, BUSY);
    tick(); tick(); cs("err_to_acc", ri2.ramstate, ACCESS);
    check("err_to_load", ri2.ramload, 32'hDEADBEEF);
    ri2.ramREN = 0; tick();

    // Reset in the middle of a write
    ri2.ramWEN = 1; ri2.ramaddr = 32'h10; ri2.ramstore = 32'h11110000;
    repeat (3) tick();
    ri2.ramWEN = 0; tick();
    ri2.ramWEN = 1; ri2.ramstore = 32'h12345678;
    tick(); cs("rst_busy", ri2.ramstate, BUSY);
    nRST = 1'b0;
    tick(); cs("rst_free", ri2.ramstate, FREE);
    check("rst_load", ri2.ramload, 32'h0);
    nRST = 1'b1; ri2.ramWEN = 0;
    tick(); cs("rst_after", ri2.ramstate, FREE);
    ri2.ramREN = 1;
    repeat (3) tick();
    cs("rst_r10_acc", ri2.ramstate, ACCESS);
    check("rst_r10_load", ri2.ramload, 32'h11110000);
    ri2.ramREN = 0;
    repeat (3) tick();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
